// File: rtl/l1_data_array.sv
// L1 cache way storage: byte-masked writes, per-entry valid bits,
// registered write-first read, and a sequential clear sweep.
module l1_data_array #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             busy,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [NB-1:0]    wmask,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             rhit
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    clr_ptr;
    logic [WIDTH-1:0] merged;
    logic             wr_en;
    logic             last;

    assign busy  = (state == CLEAR);
    assign last  = (clr_ptr == AW'(DEPTH - 1));
    // flush wins over a same-cycle write
    assign wr_en = (state == IDLE) && we && !flush;

    always_comb begin
        merged = mem[waddr];
        for (int i = 0; i < NB; i++) begin
            if (wmask[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR: begin
                if (!flush && last) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (flush) begin
                    state_nxt = CLEAR;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // pointer wraps to 0 on the sweep exit, leaving it ready for the next flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr <= '0;
        end else if (flush) begin
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (state == CLEAR) begin
            valid[clr_ptr] <= 1'b0;
        end else if (wr_en) begin
            valid[waddr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            mem[waddr] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            rhit  <= 1'b0;
        end else if (state == CLEAR) begin
            rdata <= '0;
            rhit  <= 1'b0;
        end else if (wr_en && (waddr == raddr)) begin
            rdata <= merged;
            rhit  <= 1'b1;
        end else begin
            rdata <= mem[raddr];
            rhit  <= valid[raddr];
        end
    end

endmodule

// File: tb/tb_l1_data_array.sv
// Bench for l1_data_array: reset sweep, masked writes, bypass,
// flush, reset mid-sweep, and a 32x64 instance.
module tb_l1_data_array;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         busy;
    logic         we;
    logic [2:0]   waddr;
    logic [15:0]  wmask;
    logic [127:0] wdata;
    logic [2:0]   raddr;
    logic [127:0] rdata;
    logic         rhit;

    logic         b_busy;
    logic [63:0]  b_rdata;
    logic         b_rhit;
    logic [4:0]   b_addr;
    logic [7:0]   b_mask;
    logic [63:0]  b_wdata;
    logic         b_zero;

    int tests;
    int fails;

    l1_data_array u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .we    (we),
        .waddr (waddr),
        .wmask (wmask),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata),
        .rhit  (rhit)
    );

    l1_data_array #(.WIDTH(64), .DEPTH(32)) u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (b_zero),
        .busy  (b_busy),
        .we    (b_zero),
        .waddr (b_addr),
        .wmask (b_mask),
        .wdata (b_wdata),
        .raddr (b_addr),
        .rdata (b_rdata),
        .rhit  (b_rhit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [2:0]   waddr;
        logic [15:0]  wmask;
        logic [127:0] wdata;
        logic [2:0]   raddr;
        logic [127:0] erdata;
        logic         erhit;
    } vec_t;

    typedef struct {
        logic [127:0] rdata;
        logic         rhit;
        int           id;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic count_busy(output int ns, output int nb, output logic bad);
        ns  = 0;
        nb  = 0;
        bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (busy) ns++;
            if (b_busy) nb++;
            if (busy && (rdata != '0 || rhit)) bad = 1'b1;
            if (!busy && !b_busy) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        flush = 1'b0;
        we    = 1'b0;
        waddr = '0;
        wmask = '0;
        wdata = '0;
    endtask

    logic [127:0] a5;
    logic [127:0] ones;
    logic [127:0] x11;
    logic [127:0] pat;
    int ns;
    int nb;
    logic bad;
    exp_t e;

    initial begin
        tests   = 0;
        fails   = 0;
        b_zero  = 1'b0;
        b_addr  = '0;
        b_mask  = '0;
        b_wdata = '0;
        a5   = {16{8'hA5}};
        ones = {128{1'b1}};
        x11  = {16{8'h11}};
        pat  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

        vecs[0]  = '{1'b1, 3'd5, 16'hFFFF, a5, 3'd0, 128'h0, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 16'h0000, 128'h0, 3'd5, a5, 1'b1};
        vecs[2]  = '{1'b1, 3'd5, 16'h0001, 128'hFF, 3'd4, 128'h0, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 16'h0000, 128'h0, 3'd5,
                     {a5[127:8], 8'hFF}, 1'b1};
        vecs[4]  = '{1'b1, 3'd2, 16'hFFFF, 128'h1234, 3'd2, 128'h1234, 1'b1};
        vecs[5]  = '{1'b0, 3'd0, 16'h0000, 128'h0, 3'd2, 128'h1234, 1'b1};
        vecs[6]  = '{1'b1, 3'd2, 16'h0000, ones, 3'd2, 128'h1234, 1'b1};
        vecs[7]  = '{1'b1, 3'd7, 16'h0000, ones, 3'd7, 128'h0, 1'b1};
        vecs[8]  = '{1'b0, 3'd0, 16'h0000, 128'h0, 3'd7, 128'h0, 1'b1};
        vecs[9]  = '{1'b1, 3'd3, 16'h8001, x11, 3'd5,
                     {a5[127:8], 8'hFF}, 1'b1};
        vecs[10] = '{1'b0, 3'd0, 16'h0000, 128'h0, 3'd3,
                     {8'h11, 112'h0, 8'h11}, 1'b1};
        vecs[11] = '{1'b1, 3'd6, 16'hFFFF, pat, 3'd1, 128'h0, 1'b0};
        vecs[12] = '{1'b0, 3'd0, 16'h0000, 128'h0, 3'd6, pat, 1'b1};
        vecs[13] = '{1'b1, 3'd5, 16'hFF00, 128'h0, 3'd5,
                     {64'h0, a5[63:8], 8'hFF}, 1'b1};

        rst_n = 1'b0;
        raddr = 3'd3;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {127'h0, busy}, 128'h1);
        check("reset_rdata", rdata, 128'h0);
        check("reset_rhit", {127'h0, rhit}, 128'h0);

        @(negedge clk);
        rst_n = 1'b1;
        count_busy(ns, nb, bad);
        check("sweep_len", 128'(ns), 128'd8);
        check("sweep_len_big", 128'(nb), 128'd32);
        check("sweep_rd_zero", {127'h0, bad}, 128'h0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            we    = vecs[i].we;
            waddr = vecs[i].waddr;
            wmask = vecs[i].wmask;
            wdata = vecs[i].wdata;
            raddr = vecs[i].raddr;
            sb.push_back('{vecs[i].erdata, vecs[i].erhit, i});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_rdata", e.id), rdata, e.rdata);
            check($sformatf("vec%0d_rhit", e.id), {127'h0, rhit},
                  {127'h0, e.rhit});
        end

        @(negedge clk);
        idle_inputs();
        flush = 1'b1;
        we    = 1'b1;
        waddr = 3'd1;
        wmask = 16'hFFFF;
        wdata = ones;
        raddr = 3'd0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        we    = 1'b0;
        count_busy(ns, nb, bad);
        check("flush_len", 128'(ns), 128'd8);
        check("flush_rd_zero", {127'h0, bad}, 128'h0);
        @(negedge clk);
        raddr = 3'd1;
        @(posedge clk);
        #1;
        check("flush_drop_rdata", rdata, 128'h0);
        check("flush_drop_rhit", {127'h0, rhit}, 128'h0);
        @(negedge clk);
        raddr = 3'd6;
        @(posedge clk);
        #1;
        check("flush_e6_rdata", rdata, 128'h0);
        check("flush_e6_rhit", {127'h0, rhit}, 128'h0);

        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        count_busy(ns, nb, bad);
        check("reflush_len", 128'(ns), 128'd8);

        @(negedge clk);
        we    = 1'b1;
        waddr = 3'd4;
        wmask = 16'hFFFF;
        wdata = pat;
        @(negedge clk);
        idle_inputs();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {127'h0, busy}, 128'h1);
        check("midrst_rdata", rdata, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(ns, nb, bad);
        check("midrst_len", 128'(ns), 128'd8);
        check("midrst_len_big", 128'(nb), 128'd32);
        @(negedge clk);
        raddr = 3'd4;
        @(posedge clk);
        #1;
        check("midrst_e4_rdata", rdata, 128'h0);
        check("midrst_e4_rhit", {127'h0, rhit}, 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
